// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
// Contents:
//   arb_state_e       arbitration FSM state (CPU_PRI / DMA_PRI)
//   BYTE..HALFU       funct3 access-size encodings
//   *_DEF             default starvation limit and burst length
package dmem_arb_pkg;

    typedef enum logic {
        CPU_PRI = 1'b0,
        DMA_PRI = 1'b1
    } arb_state_e;

    localparam logic [2:0] BYTE  = 3'b000;
    localparam logic [2:0] HALF  = 3'b001;
    localparam logic [2:0] WORD  = 3'b010;
    localparam logic [2:0] BYTEU = 3'b100;
    localparam logic [2:0] HALFU = 3'b101;

    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned BURST_MAX_DEF    = 8;

endpackage

// File: rtl/dmem_align_chk.sv
// rtl/dmem_align_chk.sv - combinational misalignment check for CPU accesses
// Ports:
//   funct3_i      access size (byte/half/word, signed or unsigned)
//   addr_i        low two address bits
//   misaligned_o  1 when the access straddles its natural alignment
module dmem_align_chk
    import dmem_arb_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_i,
    output logic       misaligned_o
);

    always_comb begin
        misaligned_o = 1'b0;
        case (funct3_i)
            WORD:        misaligned_o = (addr_i != 2'b00);
            HALF, HALFU: misaligned_o = addr_i[0];
            default:     misaligned_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA data-memory arbiter with DMA starvation bursts
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   MemReqM/MemWriteM/funct3M        MEM-stage request, direction, size
//   AddrM, WDataM                    MEM-stage address and store data
//   StallM, MisalignM, RDataM        CPU hold, misalignment flag, load data
//   dma_req/dma_we/dma_addr/dma_wdata DMA beat request
//   dma_gnt, dma_rdata               DMA beat accepted, read data
//   mem_we/mem_funct3/mem_addr/mem_wdata/mem_rdata  data-memory port
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned BURST_MAX    = BURST_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] AddrM,
    input  logic [31:0] WDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic [31:0] RDataM,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        mem_we,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    localparam logic [WW-1:0] WAIT_SAT  = WW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(STARVE_LIMIT - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);

    arb_state_e    state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;

    logic cpu_gnt;
    logic dma_gnt_w;
    logic dma_blocked;
    logic addr_misaligned;

    // DMA is word-only; the low address bits are deliberately dropped.
    logic unused_dma_lsbs;
    assign unused_dma_lsbs = ^dma_addr[1:0];

    dmem_align_chk u_align_chk (
        .funct3_i     (funct3M),
        .addr_i       (AddrM[1:0]),
        .misaligned_o (addr_misaligned)
    );

    // Grants are combinational from the current state so a granted access
    // completes in the same cycle. Reset masks both grants so nothing can
    // reach memory while rst is high, even mid-burst.
    always_comb begin
        cpu_gnt   = 1'b0;
        dma_gnt_w = 1'b0;
        if (!rst) begin
            if (state_q == CPU_PRI) begin
                cpu_gnt   = MemReqM;
                dma_gnt_w = ~MemReqM & dma_req;
            end else begin
                dma_gnt_w = dma_req;
            end
        end
    end

    assign dma_gnt     = dma_gnt_w;
    assign StallM      = ~rst & MemReqM & ~cpu_gnt;
    assign MisalignM   = cpu_gnt & addr_misaligned;
    assign dma_blocked = dma_req & ~dma_gnt_w;
    assign RDataM      = mem_rdata;
    assign dma_rdata   = mem_rdata;

    // Memory-side mux. A misaligned CPU access still consumes its grant,
    // only the write strobe is suppressed.
    always_comb begin
        mem_we     = 1'b0;
        mem_funct3 = 3'b000;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        if (cpu_gnt) begin
            mem_we     = MemWriteM & ~addr_misaligned;
            mem_funct3 = funct3M;
            mem_addr   = AddrM;
            mem_wdata  = WDataM;
        end else if (dma_gnt_w) begin
            mem_we     = dma_we;
            mem_funct3 = WORD;
            mem_addr   = {dma_addr[31:2], 2'b00};
            mem_wdata  = dma_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;

        if (dma_blocked) begin
            wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = '0;
        end

        case (state_q)
            CPU_PRI: begin
                // The last tolerated blocked cycle hands ownership to DMA.
                if (dma_blocked && (wait_cnt_q == WAIT_LAST)) begin
                    state_d    = DMA_PRI;
                    wait_cnt_d = '0;
                end
            end
            DMA_PRI: begin
                if (!dma_req) begin
                    state_d    = CPU_PRI;
                    beat_cnt_d = '0;
                end else if (beat_cnt_q == BEAT_LAST) begin
                    state_d    = CPU_PRI;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = CPU_PRI;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CPU_PRI;
            wait_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int SL = 4;
    localparam int BM = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReqM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] AddrM, WDataM;
    logic        StallM, MisalignM;
    logic [31:0] RDataM;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] tb_mem  [256];
    logic [31:0] ref_mem [256];

    bit ref_burst;
    int ref_wait;
    int ref_beats;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(SL), .BURST_MAX(BM)) dut (
        .clk(clk), .rst(rst),
        .MemReqM(MemReqM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .AddrM(AddrM), .WDataM(WDataM),
        .StallM(StallM), .MisalignM(MisalignM), .RDataM(RDataM),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] a,
                                          input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        case (f3)
            3'b000, 3'b100: r[8*a +: 8] = wd[7:0];
            3'b001, 3'b101: r[16*a[1] +: 16] = wd[15:0];
            default:        r = wd;
        endcase
        return r;
    endfunction

    assign mem_rdata = tb_mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[9:2]] <= merge(tb_mem[mem_addr[9:2]], mem_addr[1:0], mem_funct3, mem_wdata);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check after settling, then advance the
    // reference model as if the following rising edge had occurred.
    task automatic step(input logic r, input logic req, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
        bit cg, dg, mis, ewe, blocked;
        logic [2:0]  ef3;
        logic [31:0] ea, ewd;
        @(negedge clk);
        rst = r; MemReqM = req; MemWriteM = we; funct3M = f3; AddrM = a; WDataM = wd;
        dma_req = dr; dma_we = dwe; dma_addr = da; dma_wdata = dwd;
        #1;
        cg = 0; dg = 0;
        if (!r) begin
            if (ref_burst) dg = dr;
            else if (req) cg = 1;
            else dg = dr;
        end
        mis = cg && ((f3 == 3'b010 && a[1:0] != 2'b00) || ((f3 == 3'b001 || f3 == 3'b101) && a[0]));
        ewe = 0; ef3 = 3'b000; ea = 32'd0; ewd = 32'd0;
        if (cg) begin ewe = we && !mis; ef3 = f3; ea = a; ewd = wd; end
        else if (dg) begin ewe = dwe; ef3 = 3'b010; ea = {da[31:2], 2'b00}; ewd = dwd; end

        chk("stall",  {31'd0, StallM},    {31'd0, (!r && req && !cg)});
        chk("dmagnt", {31'd0, dma_gnt},   {31'd0, dg});
        chk("misal",  {31'd0, MisalignM}, {31'd0, mis});
        chk("memwe",  {31'd0, mem_we},    {31'd0, ewe});
        chk("memf3",  {29'd0, mem_funct3}, {29'd0, ef3});
        chk("memaddr", mem_addr, ea);
        chk("memwdat", mem_wdata, ewd);
        if (cg && !we) chk("rdata_cpu", RDataM, ref_mem[ea[9:2]]);
        if (dg && !dwe) chk("rdata_dma", dma_rdata, ref_mem[ea[9:2]]);

        if (ewe) ref_mem[ea[9:2]] = merge(ref_mem[ea[9:2]], ea[1:0], ef3, ewd);

        if (r) begin
            ref_burst = 0; ref_wait = 0; ref_beats = 0;
        end else if (!ref_burst) begin
            blocked = dr && !dg;
            if (blocked && ref_wait == SL - 1) begin ref_burst = 1; ref_wait = 0; end
            else if (blocked) ref_wait = (ref_wait < SL) ? ref_wait + 1 : SL;
            else ref_wait = 0;
        end else begin
            ref_wait = 0;
            if (!dr || ref_beats == BM - 1) begin ref_burst = 0; ref_beats = 0; end
            else ref_beats++;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0);
    endtask

    logic [2:0] f3_tab [5];

    initial begin
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
        for (int i = 0; i < 256; i++) begin tb_mem[i] = 32'd0; ref_mem[i] = 32'd0; end
        ref_burst = 0; ref_wait = 0; ref_beats = 0;
        rst = 1; MemReqM = 0; MemWriteM = 0; funct3M = 0; AddrM = 0; WDataM = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;

        // reset with both requesters active: nothing may be granted
        step(1, 1, 1, 3'b010, 32'h10, 32'h1, 1, 1, 32'h20, 32'h2);
        step(1, 0, 0, 3'b010, 32'h10, 32'h1, 1, 1, 32'h20, 32'h2);
        idle();

        // CPU store then load-back
        step(0, 1, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("st_we", {31'd0, mem_we}, 32'd1);
        step(0, 1, 0, 3'b010, 32'h10, 32'h0, 0, 0, 0, 0);
        chk("ld_data", RDataM, 32'hDEADBEEF);

        // idle-slot DMA write, low address bits dropped
        step(0, 0, 0, 3'b010, 0, 0, 1, 1, 32'h23, 32'h12345678);
        chk("dma_addr", mem_addr, 32'h20);
        chk("dma_f3", {29'd0, mem_funct3}, 32'd2);

        // misaligned half store must not touch memory
        step(0, 1, 0, 3'b010, 32'h100, 0, 0, 0, 0, 0);
        step(0, 1, 1, 3'b001, 32'h101, 32'hAAAA5555, 0, 0, 0, 0);
        chk("mis_flag", {31'd0, MisalignM}, 32'd1);
        step(0, 1, 0, 3'b010, 32'h100, 0, 0, 0, 0, 0);
        chk("mis_unchanged", RDataM, 32'h0);

        // starvation: 4 CPU cycles, then DMA owns the memory
        idle();
        for (int i = 0; i < 11; i++) begin
            step(0, 1, 0, 3'b010, 32'h20, 0, 1, 0, 32'h20, 0);
            chk("starve_gnt", {31'd0, dma_gnt}, {31'd0, (i >= SL)});
        end
        step(0, 1, 0, 3'b010, 32'h20, 0, 0, 0, 0, 0);
        chk("starve_tail", {31'd0, StallM}, 32'd1);
        step(0, 1, 0, 3'b010, 32'h20, 0, 0, 0, 0, 0);
        chk("starve_back", {31'd0, StallM}, 32'd0);

        // burst limit: at most BM beats per forced burst
        idle();
        for (int i = 0; i < SL; i++) step(0, 1, 0, 3'b010, 32'h0, 0, 1, 1, 32'h40 + 4 * i, i);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 3'b010, 32'h40, 0, 1, 1, 32'h80 + 4 * i, 32'hB0 + i);
            chk("burst_gnt", {31'd0, dma_gnt}, {31'd0, (i < BM)});
            chk("burst_stall", {31'd0, StallM}, {31'd0, (i < BM)});
        end

        // reset on the 3rd beat of a burst
        idle();
        for (int i = 0; i < SL + 2; i++) step(0, 1, 0, 3'b010, 32'h0, 0, 1, 1, 32'hC0, 32'h77);
        step(1, 1, 0, 3'b010, 32'h0, 0, 1, 1, 32'hC4, 32'h88);
        chk("rstmid_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("rstmid_we", {31'd0, mem_we}, 32'd0);
        step(0, 1, 0, 3'b010, 32'h0, 0, 1, 1, 32'hC4, 32'h88);
        chk("rstmid_cpu", {31'd0, StallM}, 32'd0);

        // randomized traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            a = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            step(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 f3_tab[$urandom_range(0, 4)], a, $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
